// File: rtl/demux_sched.sv
// demux_sched -- one-word holding demultiplexer with a round-robin channel pointer.
//
// A word accepted on the input side (IV && IR) is held and offered to one of
// eight output channels, chosen by the round-robin pointer S. The offer stays
// up until that channel's ready bit is seen. The transfer then completes: CNT
// increments, S advances, and the block returns to IDLE. IDLE and SEND
// alternate, so at most one word is accepted every two cycles.
//
// Optional feature (macro DEMUX_SCHED_TIMEOUT_EN): if the selected channel
// stays not-ready for TMO SEND cycles, the same word is re-offered to the
// next channel. CNT does not change when this happens.
//
// Parameters:
//   W    data width of I and O
//   TMO  stall cycles before a channel is skipped (1..255, macro builds only)
//
// Ports:
//   CLK    clock, rising edge
//   RST_N  asynchronous active-low reset
//   EN     enable acceptance of new input words
//   I      input data word
//   IV     input valid
//   IR     input ready (IDLE and EN)
//   O      held data word, shared by all channels
//   OV     one-hot channel valid, bit k = channel k+1
//   OR     per-channel ready, bit k = channel k+1
//   S      current channel select (round-robin pointer)
//   CNT    completed transfer count, wraps 255 -> 0
module demux_sched #(
    parameter int W   = 8,
    parameter int TMO = 15
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         EN,
    input  logic [W-1:0] I,
    input  logic         IV,
    output logic         IR,
    output logic [W-1:0] O,
    output logic [7:0]   OV,
    input  logic [7:0]   OR,
    output logic [2:0]   S,
    output logic [7:0]   CNT
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         state;
    logic [W-1:0]   hold;
    logic [7:0]     ov_q;
    logic [2:0]     sel;
    logic [7:0]     cnt;

    // Reject an out-of-range stall limit when the design is elaborated.
    if (TMO < 1 || TMO > 255) begin : g_tmo_range
        $error("demux_sched: TMO must be in 1..255");
    end

`ifdef DEMUX_SCHED_TIMEOUT_EN
    localparam logic [7:0] STALL_LAST = 8'(TMO - 1);
    logic [7:0] stall;
`endif

    function automatic logic [7:0] onehot(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

    // IR is decoded from registered state and EN only. Gating it with RST_N
    // keeps it low while reset is asserted, even though state already reads IDLE.
    assign IR  = RST_N && (state == IDLE) && EN;
    assign O   = hold;
    assign OV  = ov_q;
    assign S   = sel;
    assign CNT = cnt;

    // NOTE: every register in this block is updated with non-blocking
    // assignments. Reads of sel (e.g. onehot(sel + 1)) therefore see the
    // value from before this edge, which is what each transition relies on.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            hold  <= '0;
            ov_q  <= '0;
            sel   <= '0;
            cnt   <= '0;
`ifdef DEMUX_SCHED_TIMEOUT_EN
            stall <= '0;
`endif
        end else if (state == IDLE) begin
            if (IV && EN) begin
                hold  <= I;
                ov_q  <= onehot(sel);
                state <= SEND;
`ifdef DEMUX_SCHED_TIMEOUT_EN
                stall <= '0;
`endif
            end
        end else begin
            // SEND: only the selected channel's ready bit matters.
            // EN is ignored here, so a transfer already under way always runs to completion.
            if (OR[sel]) begin
                cnt   <= cnt + 8'd1;
                sel   <= sel + 3'd1;
                ov_q  <= '0;
                state <= IDLE;
`ifdef DEMUX_SCHED_TIMEOUT_EN
                stall <= '0;
`endif
            end
`ifdef DEMUX_SCHED_TIMEOUT_EN
            // The skip fires on the TMO-th consecutive stalled cycle.
            // Completion above takes priority if ready arrives on that same cycle.
            else if (stall == STALL_LAST) begin
                sel   <= sel + 3'd1;
                ov_q  <= onehot(sel + 3'd1);
                stall <= '0;
            end else begin
                stall <= stall + 8'd1;
            end
`endif
        end
    end

endmodule
